// File: rtl/neopixel_chain.sv
// neopixel_chain: WS2812-class one-wire LED chain driver.
// Reads per-LED colour bytes from a synchronous framebuffer RAM. The LED
// stride and bytes per LED are configurable. Each byte is scaled by a global
// brightness. The bits are sent MSB first, and a low latch window follows.
// The next byte is prefetched so that no gap appears between bytes.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   start      request one frame (level, sampled every edge)
//   free_run   1: relaunch automatically after each latch window
//   brightness global scale, sampled at frame start
//   raddr      registered framebuffer read address
//   din        framebuffer data, valid two edges after raddr is registered
//   data       registered serial LED output
//   busy       high from accepted start to end of latch
//   frame_done one-cycle pulse on the final latch cycle
module neopixel_chain #(
  parameter int NUM_LEDS      = 16,
  parameter int BYTES_PER_LED = 3,
  parameter int FB_STRIDE     = 4,
  parameter int FB_BASE       = 0,
  parameter int ADDR_W        = 9,
  parameter int T_BIT         = 25,
  parameter int T0H           = 8,
  parameter int T1H           = 16,
  parameter int RESET_CYCLES  = 1600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              free_run,
  input  logic [7:0]        brightness,
  output logic [ADDR_W-1:0] raddr,
  input  logic [7:0]        din,
  output logic              data,
  output logic              busy,
  output logic              frame_done
);
  localparam int TOTAL = NUM_LEDS * BYTES_PER_LED;
  localparam int TB_W  = $clog2(T_BIT + 1);
  localparam int BY_W  = $clog2(TOTAL + 1);
  localparam int LC_W  = $clog2(RESET_CYCLES + 1);
  localparam int K_W   = (BYTES_PER_LED > 1) ? $clog2(BYTES_PER_LED) : 1;

  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] STRIDE_A  = ADDR_W'(FB_STRIDE);
  localparam logic [TB_W-1:0]   BIT_LAST  = TB_W'(T_BIT - 1);
  localparam logic [BY_W-1:0]   BYTE_LAST = BY_W'(TOTAL - 1);
  localparam logic [BY_W-1:0]   PRE_LAST  = BY_W'(TOTAL - 2);
  localparam logic [LC_W-1:0]   LAT_LAST  = LC_W'(RESET_CYCLES - 1);
  localparam logic [K_W-1:0]    K_LAST    = K_W'(BYTES_PER_LED - 1);

  typedef enum logic [1:0] {IDLE, PRIME, SEND, LATCH} state_t;

  state_t            state_q, state_d;
  logic              prime_cnt, pending;
  logic [TB_W-1:0]   bit_timer;
  logic [2:0]        bit_cnt;
  logic [BY_W-1:0]   byte_idx;
  logic [LC_W-1:0]   latch_cnt;
  logic [ADDR_W-1:0] f_led, nled, naddr;
  logic [K_W-1:0]    f_k, nk;
  logic              vld_p0, vld_p1;
  logic [7:0]        bright_q, shift, prefetch_reg;
  logic [TB_W-1:0]   thr;
  logic              bit_end, byte_end, frame_end, latch_end;
  logic              relaunch, launch, issue;

  // (x * (b + 1)) >> 8: 255 leaves x unchanged, 0 gives 0.
  function automatic logic [7:0] scale(input logic [7:0] x, input logic [7:0] b);
    logic [16:0] p;
    p = {9'd0, x} * ({9'd0, b} + 17'd1);
    return p[15:8];
  endfunction

  assign bit_end   = (state_q == SEND) && (bit_timer == BIT_LAST);
  assign byte_end  = bit_end && (bit_cnt == 3'd7);
  assign frame_end = byte_end && (byte_idx == BYTE_LAST);
  assign latch_end = (state_q == LATCH) && (latch_cnt == LAT_LAST);
  assign relaunch  = free_run || pending || start;
  assign launch    = ((state_q == IDLE) && (start || free_run)) || (latch_end && relaunch);
  // Fetch for byte b+1 is issued when byte b begins; the final byte issues none.
  assign issue     = ((state_q == PRIME) && prime_cnt) ||
                     (byte_end && !frame_end && (byte_idx < PRE_LAST));
  assign thr       = shift[7] ? TB_W'(T1H) : TB_W'(T0H);

  // Next framebuffer address: step within the LED, then jump by the stride.
  always_comb begin
    nled = f_led;
    nk   = f_k + K_W'(1);
    if (f_k == K_LAST) begin
      nled = f_led + STRIDE_A;
      nk   = '0;
    end
    naddr = nled + ADDR_W'(nk);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start || free_run) state_d = PRIME;
      PRIME:   if (prime_cnt) state_d = SEND;
      SEND:    if (frame_end) state_d = LATCH;
      LATCH:   if (latch_end) state_d = relaunch ? PRIME : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // p0: address issued; p1: RAM access; p2: scaled byte lands in prefetch_reg
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr      <= BASE_A;
      data       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pending    <= 1'b0;
      prime_cnt  <= 1'b0;
      bit_timer  <= '0;
      bit_cnt    <= '0;
      byte_idx   <= '0;
      latch_cnt  <= '0;
      f_led      <= BASE_A;
      f_k        <= '0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p0     <= issue;
      vld_p1     <= vld_p0;
      frame_done <= 1'b0;
      if (issue) begin
        raddr <= naddr;
        f_led <= nled;
        f_k   <= nk;
      end
      unique case (state_q)
        PRIME: begin
          prime_cnt <= 1'b1;
          if (prime_cnt) begin
            data      <= 1'b1;
            bit_timer <= '0;
            bit_cnt   <= '0;
            byte_idx  <= '0;
          end
        end
        SEND: begin
          if (bit_end) begin
            bit_timer <= '0;
            if (frame_end) begin
              data       <= 1'b0;
              latch_cnt  <= '0;
              frame_done <= (RESET_CYCLES == 1);
            end else begin
              data <= 1'b1;
              if (byte_end) begin
                bit_cnt  <= '0;
                byte_idx <= byte_idx + BY_W'(1);
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end else begin
            bit_timer <= bit_timer + TB_W'(1);
            data      <= (bit_timer + TB_W'(1)) < thr;
          end
        end
        LATCH: begin
          if (latch_end) begin
            if (!relaunch) busy <= 1'b0;
          end else begin
            latch_cnt  <= latch_cnt + LC_W'(1);
            frame_done <= (latch_cnt + LC_W'(1)) == LAT_LAST;
          end
        end
        default: ;
      endcase
      if (launch) begin
        raddr     <= BASE_A;
        f_led     <= BASE_A;
        f_k       <= '0;
        busy      <= 1'b1;
        prime_cnt <= 1'b0;
        data      <= 1'b0;
      end
      // One frame may be queued; a forced free-run repeat makes a latch-time start moot.
      if (launch) pending <= 1'b0;
      else if (start && busy && !((state_q == LATCH) && free_run)) pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (launch) bright_q <= brightness;
    if ((state_q == PRIME) && prime_cnt) shift <= scale(din, bright_q);
    else if (bit_end) shift <= (bit_cnt == 3'd7) ? prefetch_reg : {shift[6:0], 1'b0};
    if (vld_p1) prefetch_reg <= scale(din, bright_q);
  end

endmodule

// File: tb/tb_neopixel_chain.sv
module tb_neopixel_chain;
  localparam int NL = 2, BPL = 3, STR = 4, BASE = 0, AW = 9;
  localparam int TBIT = 25, T0 = 8, T1 = 16, RC = 1600;
  localparam int TOTAL = NL * BPL;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, free_run = 1'b0;
  logic [7:0] brightness = 8'd255;
  logic [AW-1:0] raddr;
  logic [7:0] din = 8'd0;
  logic data, busy, frame_done;
  logic start_w = 1'b0;
  logic [AW-1:0] raddr_w;
  logic [7:0] din_w = 8'd0;
  logic data_w, busy_w, fd_w;
  logic [7:0] mem [0:511];

  neopixel_chain #(.NUM_LEDS(NL), .BYTES_PER_LED(BPL), .FB_STRIDE(STR), .FB_BASE(BASE),
    .ADDR_W(AW), .T_BIT(TBIT), .T0H(T0), .T1H(T1), .RESET_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .start(start), .free_run(free_run), .brightness(brightness),
    .raddr(raddr), .din(din), .data(data), .busy(busy), .frame_done(frame_done));

  neopixel_chain #(.NUM_LEDS(1), .BYTES_PER_LED(4), .FB_STRIDE(4), .FB_BASE(510),
    .ADDR_W(AW), .T_BIT(TBIT), .T0H(T0), .T1H(T1), .RESET_CYCLES(RC)) dut_wrap (
    .clk(clk), .rst(rst), .start(start_w), .free_run(1'b0), .brightness(8'd255),
    .raddr(raddr_w), .din(din_w), .data(data_w), .busy(busy_w), .frame_done(fd_w));

  always #5 clk = ~clk;
  always @(posedge clk) din <= mem[raddr];
  always @(posedge clk) din_w <= mem[raddr_w];

  int tests = 0, fails = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue entry per expected output cycle of a frame.
  typedef struct packed { logic d; logic b; logic fd; logic [AW-1:0] ra; } smp_t;
  smp_t q[$];
  bit pend = 0;

  function automatic logic [AW-1:0] addr_of(input int b);
    return AW'(BASE + (b / BPL) * STR + (b % BPL));
  endfunction
  function automatic logic [7:0] mscale(input logic [7:0] x, input logic [7:0] br);
    return 8'((int'(x) * (int'(br) + 1)) >> 8);
  endfunction

  task automatic build();
    smp_t s;
    logic [7:0] v;
    for (int i = 0; i < 2; i++) begin
      s.d = 0; s.b = 1; s.fd = 0; s.ra = AW'(BASE); q.push_back(s);
    end
    for (int b = 0; b < TOTAL; b++) begin
      v = mscale(mem[addr_of(b)], brightness);
      for (int i = 7; i >= 0; i--)
        for (int t = 0; t < TBIT; t++) begin
          s.d = (t < (v[i] ? T1 : T0)); s.b = 1; s.fd = 0;
          s.ra = addr_of((b + 1 < TOTAL) ? b + 1 : TOTAL - 1);
          q.push_back(s);
        end
    end
    for (int j = 0; j < RC; j++) begin
      s.d = 0; s.b = 1; s.fd = (j == RC - 1); s.ra = addr_of(TOTAL - 1); q.push_back(s);
    end
  endtask

  bit last_c, latch_c;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete(); pend = 0;
    end else if (q.size() == 0) begin
      if (start || free_run) build();
    end else begin
      last_c = (q.size() == 1);
      latch_c = (q.size() <= RC);
      void'(q.pop_front());
      if (last_c) begin
        if (free_run || pend || start) build();
        pend = 0;
      end else if (start && !(latch_c && free_run)) pend = 1;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      chk("data", data, q[0].d);
      chk("busy", busy, q[0].b);
      chk("frame_done", frame_done, q[0].fd);
      chk("raddr", raddr, q[0].ra);
    end else begin
      chk("idle_data", data, 0);
      chk("idle_busy", busy, 0);
      chk("idle_frame_done", frame_done, 0);
    end
  end

  // Observation helpers.
  int cyc = 0;
  always @(posedge clk) cyc++;
  int run = 0, pw_q[$], ra_q[$], raw_q[$], fd_times[$];
  int last_ra = -1, last_raw = -1, fd_cnt = 0, fdw_cnt = 0, rises_w = 0, rise_cyc = -1;
  int busy_low = 0;
  bit gate_busy = 0;
  logic prev_d = 0, prev_dw = 0;
  always @(negedge clk) begin
    if (data) run++;
    else if (run > 0) begin pw_q.push_back(run); run = 0; end
    if (data && !prev_d && rise_cyc < 0) rise_cyc = cyc;
    prev_d = data;
    if (busy && int'(raddr) != last_ra) begin ra_q.push_back(int'(raddr)); last_ra = int'(raddr); end
    if (busy_w && int'(raddr_w) != last_raw) begin raw_q.push_back(int'(raddr_w)); last_raw = int'(raddr_w); end
    if (data_w && !prev_dw) rises_w++;
    prev_dw = data_w;
    if (frame_done) begin fd_cnt++; fd_times.push_back(cyc); end
    if (fd_w) fdw_cnt++;
    if (gate_busy && !busy) busy_low++;
  end

  task automatic clear_obs();
    pw_q.delete(); ra_q.delete(); fd_times.delete();
    last_ra = -1; fd_cnt = 0; rise_cyc = -1; run = 0;
  endtask
  task automatic pulse_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask
  task automatic wait_fd(input int lim);
    int k = 0;
    while (!frame_done && k < lim) begin @(negedge clk); k++; end
    chk("frame_done_timeout", k < lim, 1);
    @(negedge clk);
  endtask
  task automatic wait_idle(input int lim);
    int k = 0;
    while (busy && k < lim) begin @(negedge clk); k++; end
    chk("idle_timeout", k < lim, 1);
  endtask

  logic [7:0] lit [6] = '{8'h80, 8'h01, 8'hFF, 8'h00, 8'h55, 8'hAA};
  int exp_ra [6] = '{0, 1, 2, 4, 5, 6};
  int exp_raw [4] = '{510, 511, 0, 1};
  int n8;
  logic [7:0] bv;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_data", data, 0); chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0); chk("rst_raddr", raddr, BASE);
    chk("rst_raddr_wrap", raddr_w, 510); chk("rst_busy_wrap", busy_w, 0);
    rst = 0;
    repeat (2) @(negedge clk);

    // Directed frame with known bytes; wrap instance runs alongside.
    mem[0] = 8'h80; mem[1] = 8'h01; mem[2] = 8'hFF; mem[4] = 8'h00; mem[5] = 8'h55; mem[6] = 8'hAA;
    mem[510] = 8'hC3; mem[511] = 8'h5A; brightness = 8'd255;
    clear_obs(); raw_q.delete(); last_raw = -1; rises_w = 0; fdw_cnt = 0;
    @(negedge clk); start = 1; start_w = 1;
    @(negedge clk); start = 0; start_w = 0;
    wait_fd(4000);
    repeat (2) @(negedge clk);
    chk("t1_fd_count", fd_cnt, 1);
    chk("t1_frame_len", fd_times.size() > 0 ? fd_times[0] - rise_cyc + 1 : -1, 2800);
    chk("t1_ra_count", ra_q.size(), 6);
    for (int i = 0; i < 6; i++) chk("t1_raddr_seq", i < ra_q.size() ? ra_q[i] : -1, exp_ra[i]);
    chk("t1_pulse_count", pw_q.size(), 48);
    chk("t1_first_pulse", pw_q.size() > 1 ? pw_q[0] : -1, 16);
    chk("t1_second_pulse", pw_q.size() > 1 ? pw_q[1] : -1, 8);
    for (int i = 0; i < 48; i++) begin
      bv = lit[i / 8];
      chk("t1_pulse_width", i < pw_q.size() ? pw_q[i] : -1, bv[7 - (i % 8)] ? 16 : 8);
    end
    chk("t1_busy_after", busy, 0);
    chk("wrap_fd_count", fdw_cnt, 1);
    chk("wrap_bits", rises_w, 32);
    chk("wrap_ra_count", raw_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("wrap_raddr_seq", i < raw_q.size() ? raw_q[i] : -1, exp_raw[i]);

    // Brightness 127 on 0xFF gives 0x7F; brightness 0 gives all-zero bits.
    for (int a = 0; a < 8; a++) mem[a] = 8'hFF;
    brightness = 8'd127; clear_obs();
    pulse_start(); wait_fd(4000);
    chk("b127_bit7", pw_q.size() > 7 ? pw_q[0] : -1, 8);
    for (int i = 1; i < 8; i++) chk("b127_bits", i < pw_q.size() ? pw_q[i] : -1, 16);
    wait_idle(100);
    brightness = 8'd0; clear_obs();
    pulse_start(); wait_fd(4000);
    n8 = 0;
    foreach (pw_q[i]) if (pw_q[i] == 8) n8++;
    chk("b0_all_zero_bits", n8, 48);
    chk("b0_pulse_count", pw_q.size(), 48);
    wait_idle(100);

    // Start during SEND queues exactly one frame; a second start adds nothing.
    for (int a = 0; a < 8; a++) mem[a] = 8'($urandom);
    brightness = 8'($urandom); clear_obs();
    pulse_start();
    repeat (300) @(negedge clk); pulse_start();
    repeat (100) @(negedge clk); pulse_start();
    wait_fd(4000);
    busy_low = 0; gate_busy = 1;
    wait_fd(4000);
    gate_busy = 0;
    repeat (10) @(negedge clk);
    chk("pend_fd_count", fd_cnt, 2);
    chk("pend_no_idle_gap", busy_low, 0);
    chk("pend_then_idle", busy, 0);

    // Free-running refresh for three frames.
    clear_obs();
    @(negedge clk); free_run = 1;
    wait_fd(4000); wait_fd(4000);
    free_run = 0;
    wait_fd(4000);
    repeat (5) @(negedge clk);
    chk("fr_fd_count", fd_cnt, 3);
    chk("fr_spacing1", fd_times.size() == 3 ? fd_times[1] - fd_times[0] : -1, 2802);
    chk("fr_spacing2", fd_times.size() == 3 ? fd_times[2] - fd_times[1] : -1, 2802);
    chk("fr_idle", busy, 0);

    // Randomised frames, queued starts and brightness changes mid-frame.
    for (int it = 0; it < 4; it++) begin
      wait_idle(20000);
      for (int a = 0; a < 8; a++) mem[a] = 8'($urandom);
      brightness = 8'($urandom);
      pulse_start();
      repeat ($urandom_range(0, 3500)) @(negedge clk);
      brightness = 8'($urandom);
      if ($urandom_range(0, 1) == 1) pulse_start();
    end
    wait_idle(20000);

    // Asynchronous reset while data is high, between clock edges.
    pulse_start();
    repeat (400) @(negedge clk);
    begin
      int k = 0;
      while (!data && k < 100) begin @(negedge clk); k++; end
      chk("rst_wait_high", data, 1);
    end
    #2 rst = 1;
    #1 chk("async_rst_data", data, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_raddr", raddr, BASE);
    @(negedge clk); rst = 0;
    clear_obs();
    pulse_start();
    repeat (10) @(negedge clk);
    chk("restart_raddr0", ra_q.size() > 1 ? ra_q[0] : -1, BASE);
    chk("restart_raddr1", ra_q.size() > 1 ? ra_q[1] : -1, BASE + 1);
    wait_fd(4000);
    wait_idle(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/neopixel_chain.md
Name: neopixel_chain

Overview:
Parametrised WS2812-class serial LED driver, the successor to the fixed 16-LED/48-byte neopixel driver. Reads per-LED colour bytes from the synchronous framebuffer RAM with configurable base address, stride and bytes per LED (RGB or RGBW). It applies global brightness scaling and emits MSB-first one-wire waveforms followed by a latch (reset-low) window. Supports single-shot frames on request and free-running refresh, and prefetches bytes so there is no gap at byte or frame boundaries.

Parameters:
NUM_LEDS, 16, LEDs in chain (>=1)
BYTES_PER_LED, 3, colour bytes sent per LED (3 or 4)
FB_STRIDE, 4, framebuffer bytes per LED (>=BYTES_PER_LED)
FB_BASE, 0, framebuffer address of LED 0 byte 0
ADDR_W, 9, framebuffer address width
T_BIT, 25, clk cycles per bit (20 MHz -> 1.25 us)
T0H, 8, high cycles for a 0 bit (<T1H)
T1H, 16, high cycles for a 1 bit (<T_BIT)
RESET_CYCLES, 1600, latch low cycles (80 us at 20 MHz)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  request one frame (level sampled each edge)
free_run  in  1  1: start next frame automatically after latch
brightness  in  8  global scale; sampled at frame start
raddr  out  ADDR_W  framebuffer read address (registered)
din  in  8  framebuffer data, valid 2 edges after raddr registered
data  out  1  serial LED output (registered)
busy  out  1  high from accepted start to end of latch
frame_done  out  1  one-cycle pulse on the last latch cycle

Behaviour:
- Reset (async): state=IDLE, raddr=FB_BASE, data=0, busy=0, frame_done=0, pending=0, all counters 0. Reset mid-frame drops data low immediately; no partial frame resumes.
- States: IDLE, PRIME, SEND, LATCH.
- IDLE: on an edge with start=1 or free_run=1 -> PRIME; raddr<=FB_BASE; brightness latched; busy<=1.
- PRIME: 2 cycles. At the 2nd PRIME edge, shift<=scale(din); data<=1; bit_timer<=0; go SEND.
- SEND: bit_timer counts 0..T_BIT-1. data is high for bit_timer<T0H (bit 0) or <T1H (bit 1), otherwise low. Current bit = shift[7] (MSB first). At bit_timer==T_BIT-1: shift left; next bit begins with data high.
- Prefetch: on the first cycle of each byte, raddr advances to the next byte address. din is captured 2 edges later into prefetch_reg, scaled. At the byte boundary, shift<=prefetch_reg with no idle cycle.
- Address sequence: LED n byte k -> FB_BASE + n*FB_STRIDE + k, k=0..BYTES_PER_LED-1. No fetch is issued after the last byte. Address arithmetic is modulo 2^ADDR_W.
- After the last bit of the last byte: LATCH with data=0 for RESET_CYCLES cycles. frame_done=1 on the final LATCH cycle.
- LATCH exit: if free_run or pending, go PRIME (busy stays 1) and clear pending. Otherwise go IDLE with busy<=0.
- start while busy sets pending (one frame queued; further starts while pending are ignored). start is ignored during LATCH if free_run=1 already forces a repeat.
- scale(x) = (x*(brightness+1))>>8, 16-bit product. 255 gives identity; 0 gives 0.
- Frame length from first data rise to frame_done inclusive: NUM_LEDS*BYTES_PER_LED*8*T_BIT + RESET_CYCLES cycles.

Test Plan:
- Single frame, NUM_LEDS=2, BYTES_PER_LED=3, FB_STRIDE=4, brightness=255, RAM[0..6]=0x80,0x01,0xFF,x,0x00,0x55,0xAA -> raddr sequence 0,1,2,4,5,6; first bit high 16 cycles, next 7 bits high 8 cycles each; 1200 SEND cycles, then 1600 low; frame_done once; busy falls the next cycle.
- Brightness=127 with din=0xFF -> transmitted byte 0x7F; brightness=0 -> all bits high 8 cycles.
- start pulsed mid-SEND -> exactly one extra frame follows the latch with no IDLE cycle; a second start in the same frame adds nothing.
- free_run=1 for 3 frames, then 0 -> 3 frame_done pulses spaced 2800+2 cycles apart, then IDLE.
- Async rst asserted mid-byte (no clk edge) -> data=0, busy=0 at once; after release and start, the frame restarts at FB_BASE.
- BYTES_PER_LED=4, FB_STRIDE=4, NUM_LEDS=1, FB_BASE=510, ADDR_W=9 -> raddr 510,511,0,1 (wrap); 32 bits sent.
